// File: rtl/matrix_add_sequencer.sv
// Element-wise matrix adder: fetches operand pairs one index at a time, adds them
// and presents each sum on a valid/ready result port, with a sticky carry-out flag.
module matrix_add_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_ELEM = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [3:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_a,
    input  logic [DATA_W-1:0] rd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int unsigned AW = 4;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_ELEM - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ADD   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                rd_en_q, rd_en_d;
    logic                res_valid_q, res_valid_d;
    logic [AW-1:0]       res_addr_q, res_addr_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W:0]     sum_c;

    // One extra bit keeps the carry-out of the element sum
    assign sum_c = (DATA_W+1)'(rd_a) + (DATA_W+1)'(rd_b);

    // Next-state and next-output logic; registered outputs decode the next state
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;
        ovf_d      = ovf_q;

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = FETCH;
                    end
                end
                FETCH: state_d = ADD;
                ADD: begin
                    res_data_d = sum_c[DATA_W-1:0];
                    res_addr_d = idx_q;
                    ovf_d      = ovf_q | sum_c[DATA_W];
                    state_d    = WRITE;
                end
                WRITE: begin
                    if (res_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = FETCH;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        rd_en_d     = (state_d == FETCH);
        res_valid_d = (state_d == WRITE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rd_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_en_q     <= rd_en_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = idx_q;
    assign res_valid = res_valid_q;
    assign res_addr  = res_addr_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/matrix_add_sequencer.md
MATRIX_ADD_SEQUENCER -- requirements
Module: matrix_add_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the element width in bits.
REQ-002 The block SHALL have parameter N_ELEM, default 9, meaning elements per matrix (3x3); legal range 1..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request one full matrix addition.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous cancel of the running operation.
REQ-007 The block SHALL have port rd_en, output, 1 bit: operand read strobe.
REQ-008 The block SHALL have port rd_addr, output, 4 bits: element index being read.
REQ-009 The block SHALL have ports rd_a and rd_b, input, DATA_W bits each: operands, valid exactly one cycle after rd_en.
REQ-010 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port res_addr, output, 4 bits: element index of res_data.
REQ-013 The block SHALL have port res_data, output, DATA_W bits: element sum.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have port ovf, output, 1 bit: sticky carry-out flag.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, FETCH, ADD, WRITE and DONE.
REQ-018 In IDLE with start=1, the FSM SHALL clear the index and ovf and go to FETCH; start SHALL be ignored in all other states.
REQ-019 In FETCH, rd_en SHALL be 1 and rd_addr SHALL equal the index for one cycle, and the FSM SHALL then go to ADD.
REQ-020 In ADD, the block SHALL register res_data = (rd_a + rd_b) mod 2^DATA_W and res_addr = index, OR the carry-out into ovf, and go to WRITE.
REQ-021 In WRITE, res_valid SHALL be 1, with res_data and res_addr held stable until res_valid and res_ready are both high.
REQ-022 On a WRITE handshake with index = N_ELEM-1, the FSM SHALL go to DONE; otherwise it SHALL increment the index and go to FETCH.
REQ-023 DONE SHALL last one cycle with done=1, and the FSM SHALL then go to IDLE.
REQ-024 With res_ready held at 1, the per-element latency SHALL be 3 cycles, and done SHALL be high in cycle 3*N_ELEM+1 after the edge that samples start (28 for the default).
REQ-025 abort=1 in any non-IDLE state SHALL send the FSM to IDLE on the next edge, with res_valid=0 and no done pulse; abort SHALL take priority over the handshake in the same cycle.
REQ-026 rd_en SHALL be 0 outside FETCH, and res_valid SHALL be 0 outside WRITE.
REQ-027 ovf SHALL hold its value through DONE and IDLE until the next accepted start.
REQ-028 rd_addr and res_addr SHALL never exceed N_ELEM-1.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, index 0, rd_en=0, rd_addr=0, res_valid=0, res_addr=0, res_data=0, busy=0, done=0, ovf=0.
REQ-030 A reset asserted mid-operation SHALL discard the operation with no done pulse, and the first start after rst_n rises SHALL begin at index 0.

Verification
REQ-031 Scenario: rd_a=k and rd_b=2k for k=0..8, res_ready=1, start pulse -> results 0,3,...,24 at res_addr 0..8, done in cycle 28, ovf=0.
REQ-032 Scenario: element 4 operands 0xFFFF+0x0002 -> res_data=0x0001, ovf=1 after the run, ovf cleared by the next start.
REQ-033 Scenario: res_ready=0 for 5 cycles during element 2 -> res_valid stays 1, res_data/res_addr stable, all later timing shifted by exactly 5 cycles.
REQ-034 Scenario: abort in WRITE of element 6 together with res_ready=1 -> IDLE next cycle, no done, busy=0.
REQ-035 Scenario: start re-pulsed while busy, then rst_n low during FETCH of element 3 -> second start ignored, all outputs reset immediately, next run starts at index 0.
